// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty meter: FSM state encoding,
// default sizing constants and the percent scaling factor.
package pwm_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 1000;
    localparam int unsigned PCT_SCALE   = 100;

endpackage

// File: rtl/pwm_meter_div.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// A start pulse while busy aborts the running division and reloads the operands.
module pwm_meter_div
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned DW    = CNT_W + 7,
    parameter int unsigned QW    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    quotient
);

    localparam int unsigned CW = $clog2(DW + 1);
    localparam logic [CW-1:0] ITERS   = CW'(DW);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [QW-1:0]    quotient_q, quotient_d;
    logic [CNT_W:0]   rem_shift;

    always_comb begin
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quotient_d = quotient_q;
        rem_shift  = {rem_q, quo_q[DW-1]};

        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            div_d  = divisor;
            cnt_d  = ITERS;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // quo_q doubles as the dividend shift register and the quotient accumulator
            if (rem_shift >= {1'b0, div_q}) begin
                rem_d = CNT_W'(rem_shift - {1'b0, div_q});
                quo_d = {quo_q[DW-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[CNT_W-1:0];
                quo_d = {quo_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                quotient_d = quo_d[QW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quotient_q <= '0;
        end else begin
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quotient_q <= quotient_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quotient_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an asynchronous PWM input, flags stuck levels.
// Define PWM_METER_DUTY_EN to add the duty-percent divider; otherwise duty outputs are tied to 0.
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low,
    output logic [6:0]       duty_pct,
    output logic             duty_valid
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    meter_state_e     state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync3_q, sync3_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q, stuck_low_d;

    // sync3_q is the synchronized level aligned with rise_q
    always_comb begin
        sync1_d      = pwm_in;
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        rise_d       = sync2_q & ~sync3_q;
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;

        if (rise_q) begin
            period_cnt_d = ONE;
            high_cnt_d   = ONE;
            state_d      = MEASURE;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            if (state_q == MEASURE) begin
                period_d     = period_cnt_q;
                high_time_d  = high_cnt_q;
                meas_valid_d = 1'b1;
            end
        end else begin
            period_cnt_d = (period_cnt_q >= TIMEOUT_C) ? TIMEOUT_C : period_cnt_q + ONE;
            if (sync3_q && (high_cnt_q < TIMEOUT_C)) begin
                high_cnt_d = high_cnt_q + ONE;
            end
            if (period_cnt_d == TIMEOUT_C) begin
                state_d      = IDLE;
                stuck_high_d = sync3_q;
                stuck_low_d  = ~sync3_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            rise_q       <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            rise_q       <= rise_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;

`ifdef PWM_METER_DUTY_EN
    localparam int unsigned DW = CNT_W + 7;

    logic [DW-1:0] dividend;
    logic          div_busy;
    logic          div_done;

    // Starting from the _d operands lets the divider load on the same edge as meas_valid
    always_comb dividend = DW'(high_time_d) * DW'(PCT_SCALE);

    pwm_meter_div #(
        .CNT_W (CNT_W),
        .DW    (DW),
        .QW    (7)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (meas_valid_d),
        .dividend (dividend),
        .divisor  (period_d),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (duty_pct)
    );

    assign duty_valid = div_done & ~div_busy;
`else
    assign duty_pct   = '0;
    assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: stimulus pushes expected measurements,
// a negedge monitor pops and compares them when the DUT reports.
`timescale 1ns/1ps
module tb_pwm_duty_meter;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 1000;
    localparam int unsigned DIV_LAT = CNT_W + 7;

    typedef struct {
        int unsigned per;
        int unsigned hi;
        int unsigned due;
    } meas_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;
    logic [6:0]       duty_pct;
    logic             duty_valid;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    meas_t       exp_q[$];
    meas_t       m;
    bit          armed = 1'b0;
    int unsigned rise_cyc = 0;
    int unsigned high_len = 0;
    int unsigned last_p = 0;
    int unsigned last_h = 0;
    bit          duty_pend = 1'b0;
    int unsigned duty_exp = 0;
    int unsigned duty_due = 0;
    int unsigned n_duty = 0;

    pwm_duty_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low),
        .duty_pct   (duty_pct),
        .duty_valid (duty_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (meas_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL meas_unexpected: period=%0d high_time=%0d at cyc %0d, required no meas_valid",
                             period, high_time, cyc);
                end else begin
                    m = exp_q.pop_front();
                    if (period !== CNT_W'(m.per) || high_time !== CNT_W'(m.hi) || cyc != m.due) begin
                        n_fail++;
                        $display("FAIL meas: period=%0d high_time=%0d cyc=%0d, required period=%0d high_time=%0d cyc=%0d",
                                 period, high_time, cyc, m.per, m.hi, m.due);
                    end
                    last_p = m.per;
                    last_h = m.hi;
`ifdef PWM_METER_DUTY_EN
                    duty_pend = 1'b1;
                    duty_exp  = (m.hi * 100) / m.per;
                    duty_due  = cyc + DIV_LAT;
`else
                    n_checks++;
                    if (duty_pct !== 7'd0) begin
                        n_fail++;
                        $display("FAIL duty_tied: duty_pct=%0d, required 0", duty_pct);
                    end
`endif
                end
            end
`ifdef PWM_METER_DUTY_EN
            if (duty_valid) begin
                n_checks++;
                n_duty++;
                if (!duty_pend || cyc != duty_due || duty_pct !== 7'(duty_exp)) begin
                    n_fail++;
                    $display("FAIL duty: duty_pct=%0d cyc=%0d pending=%0d, required duty_pct=%0d cyc=%0d pending=1",
                             duty_pct, cyc, duty_pend, duty_exp, duty_due);
                end
                duty_pend = 1'b0;
            end else if (duty_pend && cyc >= duty_due) begin
                n_checks++;
                n_fail++;
                $display("FAIL duty_missing: no duty_valid at cyc %0d, required pulse with duty_pct=%0d",
                         cyc, duty_exp);
                duty_pend = 1'b0;
            end
`else
            if (duty_valid) begin
                n_checks++;
                n_fail++;
                $display("FAIL duty_valid_tied: duty_valid=1 at cyc %0d, required 0", cyc);
            end
`endif
        end
    end

    // Drive a level for n cycles; rising edges record the expected measurement of the prior period.
    task automatic drive_level(input logic v, input int unsigned n);
        @(negedge clk);
        if (v && !pwm_in) begin
            if (armed && (cyc - rise_cyc) < TIMEOUT)
                exp_q.push_back('{per: cyc - rise_cyc, hi: high_len, due: cyc + 4});
            armed    = 1'b1;
            rise_cyc = cyc;
        end else if (!v && pwm_in) begin
            high_len = cyc - rise_cyc;
        end
        pwm_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic drive_period(input int unsigned p, input int unsigned h);
        drive_level(1'b1, h);
        drive_level(1'b0, p - h);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({period, high_time, meas_valid, stuck_high, stuck_low, duty_pct, duty_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: period=%0d high_time=%0d mv=%0b sh=%0b sl=%0b duty=%0d dv=%0b, required all 0",
                     period, high_time, meas_valid, stuck_high, stuck_low, duty_pct, duty_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({period, high_time, meas_valid, stuck_high, stuck_low} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: period=%0d high_time=%0d mv=%0b sh=%0b sl=%0b, required all 0",
                     period, high_time, meas_valid, stuck_high, stuck_low);
        end
    endtask

    task automatic test_basic();
        repeat (6) drive_period(10, 5);
        drive_level(1'b1, 5);
        drive_level(1'b0, 35);
        n_checks++;
        if (period !== 16'd10 || high_time !== 16'd5) begin
            n_fail++;
            $display("FAIL basic_steady: period=%0d high_time=%0d, required 10/5", period, high_time);
        end
`ifdef PWM_METER_DUTY_EN
        n_checks++;
        if (duty_pct !== 7'd50) begin
            n_fail++;
            $display("FAIL basic_duty: duty_pct=%0d, required 50", duty_pct);
        end
`endif
    endtask

    task automatic test_duty_step();
        repeat (4) drive_period(10, 3);
        repeat (4) drive_period(10, 7);
        drive_level(1'b1, 7);
        drive_level(1'b0, 30);
        n_checks++;
        if (period !== 16'd10 || high_time !== 16'd7) begin
            n_fail++;
            $display("FAIL step_steady: period=%0d high_time=%0d, required 10/7", period, high_time);
        end
`ifdef PWM_METER_DUTY_EN
        n_checks++;
        if (duty_pct !== 7'd70) begin
            n_fail++;
            $display("FAIL step_duty: duty_pct=%0d, required 70", duty_pct);
        end
`endif
    endtask

    task automatic test_stuck();
        int unsigned r;
        drive_level(1'b1, 4);
        r = rise_cyc;
        drive_level(1'b0, 1);
        while (cyc < r + TIMEOUT + 2) @(negedge clk);
        n_checks++;
        if (stuck_low !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_low_early: stuck_low=%0b at cyc %0d, required 0", stuck_low, cyc);
        end
        @(negedge clk);
        n_checks++;
        if (stuck_low !== 1'b1 || stuck_high !== 1'b0 ||
            period !== CNT_W'(last_p) || high_time !== CNT_W'(last_h)) begin
            n_fail++;
            $display("FAIL stuck_low: sl=%0b sh=%0b period=%0d high_time=%0d, required sl=1 sh=0 period=%0d high_time=%0d",
                     stuck_low, stuck_high, period, high_time, last_p, last_h);
        end
        drive_level(1'b1, 4);
        r = rise_cyc;
        @(negedge clk);
        n_checks++;
        if (stuck_low !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_low_clear: stuck_low=%0b, required 0", stuck_low);
        end
        while (cyc < r + TIMEOUT + 2) @(negedge clk);
        n_checks++;
        if (stuck_high !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_high_early: stuck_high=%0b at cyc %0d, required 0", stuck_high, cyc);
        end
        @(negedge clk);
        n_checks++;
        if (stuck_high !== 1'b1 || stuck_low !== 1'b0 ||
            period !== CNT_W'(last_p) || high_time !== CNT_W'(last_h)) begin
            n_fail++;
            $display("FAIL stuck_high: sh=%0b sl=%0b period=%0d high_time=%0d, required sh=1 sl=0 period=%0d high_time=%0d",
                     stuck_high, stuck_low, period, high_time, last_p, last_h);
        end
    endtask

    task automatic test_restart();
        drive_level(1'b0, 3);
        drive_level(1'b1, 5);
        n_checks++;
        if (stuck_high !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: stuck_high=%0b, required 0", stuck_high);
        end
        drive_level(1'b0, 15);
        repeat (2) drive_period(20, 5);
        drive_level(1'b1, 5);
        drive_level(1'b0, 5);
        n_checks++;
        if (period !== 16'd20 || high_time !== 16'd5) begin
            n_fail++;
            $display("FAIL restart_meas: period=%0d high_time=%0d, required 20/5", period, high_time);
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) drive_period(10, 5);
        drive_level(1'b1, 2);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        exp_q.delete();
        armed     = 1'b0;
        duty_pend = 1'b0;
        #1;
        n_checks++;
        if ({period, high_time, meas_valid, stuck_high, stuck_low, duty_pct, duty_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: period=%0d high_time=%0d mv=%0b sh=%0b sl=%0b duty=%0d dv=%0b, required all 0",
                     period, high_time, meas_valid, stuck_high, stuck_low, duty_pct, duty_valid);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive_period(10, 5);
    endtask

    task automatic test_back_to_back();
        int unsigned d0;
        d0 = n_duty;
        repeat (4) drive_period(4, 2);
        repeat (4) drive_period(3, 1);
        drive_level(1'b1, 1);
        drive_level(1'b0, 40);
        n_checks++;
        if (period !== 16'd3 || high_time !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_meas: period=%0d high_time=%0d, required 3/1", period, high_time);
        end
        n_checks++;
`ifdef PWM_METER_DUTY_EN
        if (duty_pct !== 7'd33 || (n_duty - d0) != 1) begin
            n_fail++;
            $display("FAIL b2b_duty: duty_pct=%0d reports=%0d, required duty_pct=33 reports=1",
                     duty_pct, n_duty - d0);
        end
`else
        if (duty_pct !== 7'd0 || n_duty != d0) begin
            n_fail++;
            $display("FAIL b2b_duty: duty_pct=%0d reports=%0d, required 0/0", duty_pct, n_duty - d0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_step();
        test_stuck();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || duty_pend) begin
            n_fail++;
            $display("FAIL drain: %0d measurements outstanding, duty pending=%0d, required 0/0",
                     exp_q.size(), duty_pend);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
